// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: operand width, ALU command encoding
// and arbiter index/vector types.
package Types;
  localparam int OP_W = 32;
  typedef logic [OP_W-1:0] op_t;
endpackage

package ALUType;
  // Encodings 5..7 are undefined and make the ALU produce zero.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_cmd_t;
endpackage

package AluArbType;
  localparam int N_REQ_MAX = 4;
  typedef logic [1:0] req_idx_t;
  typedef logic [N_REQ_MAX-1:0] req_vec_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: add/sub with signed overflow, bitwise ops,
// zero flag on the result.
module ALU
  import Types::*;
  import ALUType::*;
(
  input  alu_cmd_t cmd,
  input  op_t      a,
  input  op_t      b,
  output op_t      out,
  output logic     overflow,
  output logic     zero
);
  op_t sum;
  op_t diff;

  always_comb begin
    sum      = a + b;
    diff     = a - b;
    out      = '0;
    overflow = 1'b0;
    case (cmd)
      ALU_ADD: begin
        out      = sum;
        overflow = (a[OP_W-1] == b[OP_W-1]) && (sum[OP_W-1] != a[OP_W-1]);
      end
      ALU_SUB: begin
        out      = diff;
        overflow = (a[OP_W-1] != b[OP_W-1]) && (diff[OP_W-1] != a[OP_W-1]);
      end
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_XOR: out = a ^ b;
      default: out = '0;
    endcase
    zero = (out == '0);
  end
endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational picker: first eligible index at or after ptr, falling back to
// plain lowest-index priority. With ptr tied to 0 it is a fixed-priority picker.
module rr_pick
  import AluArbType::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] elig,
  input  req_idx_t         ptr,
  output logic [N_REQ-1:0] grant,
  output req_idx_t         idx,
  output logic             any
);
  logic [N_REQ-1:0] masked;

  function automatic req_idx_t first_set(input logic [N_REQ-1:0] v);
    first_set = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) first_set = req_idx_t'(i);
    end
  endfunction

  always_comb begin
    masked = '0;
    for (int i = 0; i < N_REQ; i++) begin
      masked[i] = elig[i] && (req_idx_t'(i) >= ptr);
    end
    any = |elig;
    idx = (|masked) ? first_set(masked) : first_set(elig);
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = any && (idx == req_idx_t'(i));
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates N_REQ requesters onto one shared ALU and registers each result in
// a per-requester response slot. Define ALU_ARB_RR_EN for round-robin; default is fixed priority.
module alu_arbiter
  import Types::*;
  import ALUType::*;
  import AluArbType::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  alu_cmd_t         req_cmd [N_REQ],
  input  op_t              req_a   [N_REQ],
  input  op_t              req_b   [N_REQ],
  output logic [N_REQ-1:0] rsp_valid,
  input  logic [N_REQ-1:0] rsp_ready,
  output op_t              rsp_out [N_REQ],
  output logic [N_REQ-1:0] rsp_overflow,
  output logic [N_REQ-1:0] rsp_zero
);
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  req_idx_t         idx;
  req_idx_t         ptr;
  logic             any;

  alu_cmd_t alu_cmd;
  op_t      alu_a, alu_b, alu_out;
  logic     alu_ovf, alu_zero;

  logic [N_REQ-1:0] rsp_valid_d, rsp_valid_q;
  logic [N_REQ-1:0] rsp_ovf_d, rsp_ovf_q;
  logic [N_REQ-1:0] rsp_zero_d, rsp_zero_q;
  op_t              rsp_out_d [N_REQ];
  op_t              rsp_out_q [N_REQ];

  // A slot draining this cycle may be refilled; nothing is accepted during reset.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready) & {N_REQ{~rst}};

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

`ifdef ALU_ARB_RR_EN
  req_idx_t ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (any) ptr_d = (idx == req_idx_t'(N_REQ - 1)) ? '0 : idx + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    alu_cmd = ALU_AND;
    alu_a   = '0;
    alu_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (any && idx == req_idx_t'(i)) begin
        alu_cmd = req_cmd[i];
        alu_a   = req_a[i];
        alu_b   = req_b[i];
      end
    end
  end

  ALU u_alu (
    .cmd      (alu_cmd),
    .a        (alu_a),
    .b        (alu_b),
    .out      (alu_out),
    .overflow (alu_ovf),
    .zero     (alu_zero)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i] & ~rsp_ready[i];
      rsp_out_d[i]   = rsp_out_q[i];
      rsp_ovf_d[i]   = rsp_ovf_q[i];
      rsp_zero_d[i]  = rsp_zero_q[i];
      if (grant[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_out_d[i]   = alu_out;
        rsp_ovf_d[i]   = alu_ovf;
        rsp_zero_d[i]  = alu_zero;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_ovf_q   <= '0;
      rsp_zero_q  <= '0;
      for (int i = 0; i < N_REQ; i++) rsp_out_q[i] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_zero_q  <= rsp_zero_d;
      for (int i = 0; i < N_REQ; i++) rsp_out_q[i] <= rsp_out_d[i];
    end
  end

  assign req_ready    = grant;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_zero     = rsp_zero_q;
  always_comb begin
    for (int i = 0; i < N_REQ; i++) rsp_out[i] = rsp_out_q[i];
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU among `N_REQ` requesters, such as the issue port and the address-generation port. Each cycle it grants one valid request, drives the shared ALU with that request's operands, and captures the result in that requester's response register. The result is held until the requester accepts it. The block sits between the pipeline front-ends and the one ALU instance it owns.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters; legal range 2..4.

Ports (index `i` in 0..N_REQ-1):
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  N_REQ: request `i` is present.
- `req_ready`  out  N_REQ: request `i` is accepted this cycle; the transfer happens when `req_valid[i] & req_ready[i]`.
- `req_cmd`  in  N_REQ x alu_cmd_t: ALU command per requester.
- `req_a`, `req_b`  in  N_REQ x op_t: operands per requester.
- `rsp_valid`  out  N_REQ: response register `i` holds a result.
- `rsp_ready`  in  N_REQ: requester `i` consumes its response.
- `rsp_out`  out  N_REQ x op_t: registered ALU result.
- `rsp_overflow`, `rsp_zero`  out  N_REQ: registered ALU flags.

## Operation
- Response slot `i` is **free** when `!rsp_valid[i] | rsp_ready[i]`, so a slot that drains this cycle counts as free.
- **Eligible** requesters: `req_valid[i]` is high and slot `i` is free.
- **Grant:**
  - Exactly one eligible requester is granted per cycle, or none if nobody is eligible.
  - `req_ready` is one-hot or zero.
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`.
- **Datapath:**
  - The shared ALU receives the granted requester's `cmd/a/b`.
  - When nothing is granted, the ALU inputs are driven to `cmd`=AND, `a`=0, `b`=0.
- **Capture on grant:**
  - `rsp_out[g]`, `rsp_overflow[g]` and `rsp_zero[g]` load the ALU outputs.
  - `rsp_valid[g]` is set to 1.
- **Drain:** if slot `i` has `rsp_ready[i]` high and was not refilled this cycle, `rsp_valid[i]` clears to 0.
  - The data registers keep their last value.
- **Drain plus refill in the same cycle:** the slot holds the new result and `rsp_valid` stays 1.
- **Round-robin pointer** `ptr` (req_idx_t):
  - Priority order is `ptr`, `ptr+1`, … modulo `N_REQ`.
  - After a grant to `g`, `ptr` becomes `(g+1) mod N_REQ`.
  - When no grant is made, `ptr` is unchanged.
  - Wrap-around: granting `N_REQ-1` sets `ptr` to 0.
- **Undefined command:** the ALU yields `out`=0, so the response carries 0 with `zero`=1.
- **Protocol rule for requesters:** `req_*` must be held stable while `req_valid` is high and `req_ready` is low. The arbiter does not check this.

## Timing
- **Latency:** a request accepted in cycle N has `rsp_valid` high in cycle N+1 with its result.
- **Throughput:** one result per cycle across all requesters; one per cycle per requester when it is uncontended and `rsp_ready` is held high.
- **Reset:**
  - Clears `rsp_valid` to 0, `rsp_out` to 0, `rsp_overflow` and `rsp_zero` to 0, and `ptr` to 0.
  - `req_ready` is 0 while `rst` is high.
- **Reset mid-operation:** pending responses are discarded and never delivered; any in-flight request is not accepted.
- There is no combinational path from `req_*` to `rsp_*`.

## Configuration
- **`ALU_ARB_RR_EN` defined:** round-robin arbitration as described under Operation.
- **`ALU_ARB_RR_EN` not defined:**
  - Fixed priority: the lowest eligible index always wins.
  - `ptr` is not implemented; no register is inferred for it.
  - Starvation of higher indices is permitted.

## Structure
- **Package `AluArbType`:**
  - constant `N_REQ_MAX` = 4;
  - `typedef logic [1:0] req_idx_t`;
  - `typedef logic [N_REQ_MAX-1:0] req_vec_t`.
- **Reused types:** `op_t` from `Types` and `alu_cmd_t` from `ALUType`.
- **Sub-module `rr_pick`:**
  - Combinational.
  - Inputs: eligible vector and `ptr`.
  - Outputs: one-hot grant, grant index and `any`.
  - Has an internal fixed-priority path for the non-RR build.
- **Top level:** instantiates `rr_pick` and `ALU`, the grant mux, the response registers and `ptr`.

## Test plan
1. **Single request:** `req_valid[0]`=1, ADD 5+7, `rsp_ready[0]`=1.
   - `req_ready[0]`=1 in cycle 0.
   - Cycle 1: `rsp_valid[0]`=1, `rsp_out[0]`=12, `zero`=0, `overflow`=0.
2. **Full contention:** both requesters valid every cycle, both `rsp_ready`=1, RR build.
   - Grants go 0,1,0,1 over 4 cycles.
   - Non-RR build: grants go 0,0,0,0 and `req_ready[1]` stays 0.
3. **Overflow:** ADD 0x7FFFFFFF+1 gives `rsp_out`=0x80000000, `overflow`=1. SUB 3-3 gives `rsp_out`=0, `zero`=1.
4. **Backpressure:** `rsp_valid[0]`=1 and `rsp_ready[0]`=0, with requesters 0 and 1 both valid.
   - `req_ready[0]`=0 and `req_ready[1]`=1.
   - Slot 0 data is unchanged until `rsp_ready[0]` rises.
5. **Drain and refill in the same cycle:** slot 0 full with `rsp_ready[0]`=1 and a new OR 0xF0|0x0F from requester 0.
   - `req_ready[0]`=1.
   - Next cycle: `rsp_valid[0]` stays 1 and `rsp_out[0]`=0xFF.
6. **Reset mid-operation:** assert `rst` asynchronously while both `rsp_valid`=1 and `ptr`=1.
   - `rsp_valid` drops to 0 immediately.
   - After release, the first contended grant goes to requester 0.
